dm_lsu: RTL
===========

# dm_lsu

Core-side load/store unit that initiates all RISC-V core accesses to the data memory block. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-addressed, byte-enabled accesses. It handles the memory's one-cycle synchronous read latency, byte-lane mapping, and sign/zero extension, and returns one response per request over a valid/ready handshake. It sits between the core's memory stage and the data memory's core port, in the core_clk domain.

## Interface
- `DATAMEM_BITS`, 14: word-address width of the data memory. The byte address width is DATAMEM_BITS+2.
- `core_clk` in 1: gated core clock. Nothing is sampled on any other clock.
- `nrst` in 1: synchronous, active-low reset, sampled on core_clk.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a core_clk edge where req_valid && req_ready.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU). Ignored for stores and words.
- `req_addr` in DATAMEM_BITS+2: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data. 0 for stores and errors.
- `rsp_err` out 1: request rejected, no memory access made. Qualified by rsp_valid.
- `dm_write` out 4: byte-lane write enables to the data memory. Bit k enables byte offset k.
- `data_addr` out DATAMEM_BITS: word address to the data memory.
- `data_in` out 32: write data to the data memory. Byte offset k is driven on bits [31-8k:24-8k].
- `data_out` in 32: read data from the data memory, valid the cycle after the address is presented. Byte offset k arrives on bits [8k+7:8k].

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ISSUE2, CAPTURE2, RESP. req_ready = (state == IDLE).
- On accept, the unit latches the request.
  - Illegal request (req_size==3, or misaligned without the split feature): go to RESP with rsp_err=1. No access is made.
  - Otherwise: load the data_addr, dm_write and data_in registers and go to ISSUE.
- dm_write is nonzero only in ISSUE/ISSUE2 for stores. It is 0 in every other state and for all loads.
- Store byte mapping: byte j of req_wdata (LSB = j0) is written to byte offset (addr[1:0]+j).
  - SB at offset 3 gives dm_write=4'b1000 and data_in[7:0]=byte.
- Load data: bytes are assembled from data_out at the same offsets. Half and byte results are sign-extended, or zero-extended if req_unsigned.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
- Store FSM path: IDLE→ISSUE→RESP→IDLE.
- Load FSM path: IDLE→ISSUE→CAPTURE (data_out registered into rsp_rdata)→RESP→IDLE.
- RESP lasts exactly one cycle. rsp_valid/rsp_err/rsp_rdata are registered.
- Accesses in the upper region (data_addr MSB=1, protocol/SFR space) are handled identically. The unit never decodes regions.

## Timing
- Accept at edge T.
- ISSUE is cycle T+1: data_addr, dm_write and data_in are stable for the whole cycle.
- Store: rsp_valid at T+2. Load: rsp_valid at T+3. Error: rsp_valid at T+1.
- The next accept is possible at the edge ending RESP. Maximum throughput is 1 store per 3 cycles and 1 load per 4 cycles.
- Reset values: state IDLE, req_ready 1 after reset, dm_write 0, data_addr 0, data_in 0, rsp_valid 0, rsp_err 0, rsp_rdata 0.
- Reset mid-operation: the next edge forces reset values. The in-flight request is dropped with no response. A write already presented in ISSUE completes only if that edge was not a reset edge.
- req_valid is ignored outside IDLE. No request queueing.

## Configuration
- `DM_LSU_MISALIGNED_SPLIT_EN` defined:
  - Misaligned accesses within one word (half at offset 1) use a single access.
  - Word-crossing accesses split into two:
    - First access: word addr[..:2], lanes offset..3.
    - Second access: word (addr[..:2]+1) mod 2^DATAMEM_BITS, remaining lanes from 0.
  - Split store path: ISSUE(T+1), ISSUE2(T+2), RESP(T+3).
  - Split load path: ISSUE(T+1), CAPTURE(T+2), ISSUE2(T+3), CAPTURE2(T+4), RESP(T+5).
  - req_size==3 is still an error.
- Undefined: every misaligned access returns rsp_err=1 at T+1 and makes no memory access. ISSUE2/CAPTURE2 are not synthesized.

## Test plan
- SW 0x11223344 @0x0040 → T+1: data_addr 0x010, dm_write 4'b1111, data_in 0x44332211; rsp at T+2. Then LW @0x0040 → rsp_rdata 0x11223344 at T+3.
- SB 0xA5 @0x0043 → dm_write 4'b1000, data_in[7:0]=0xA5. LB @0x0043 → 0xFFFFFFA5. LBU → 0x000000A5.
- SH 0x8001 @0x0042, then LH → 0xFFFF8001, LHU → 0x00008001. dm_write for the store is 4'b1100.
- LH @0x0041, macro off → rsp_err=1 at T+1, dm_write stays 0. Macro on → single access, correct data at T+3.
- Macro on: SW 0xDEADBEEF @0x0046 → word 0x011 with lanes 4'b1100, then word 0x012 with lanes 4'b0011. LW @0x0046 → 0xDEADBEEF at T+5. SW @0xFFFE wraps its second access to word 0x000.
- nrst low during ISSUE of a store → next edge: dm_write 0, state IDLE, no rsp_valid. Back-to-back LW @0x8040 (cycle counter) returns strictly increasing values.

Source files
------------

// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dm_lsu
// Purpose  : Core-side load/store unit for the data memory core port.
//            Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into
//            word-addressed, byte-enabled accesses, absorbs the memory's
//            one-cycle synchronous read latency, maps byte lanes and
//            sign/zero-extends load data. One response per request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   DM_LSU_MISALIGNED_SPLIT_EN - when defined, misaligned accesses are served
//   (word-crossing ones as two back-to-back accesses). When undefined, every
//   misaligned access is rejected with rsp_err and no memory access.
// ----------------------------------------------------------------------------
// Ports:
//   core_clk      in   gated core clock (only clock)
//   nrst          in   synchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  high in IDLE; accept on req_valid && req_ready
//   req_we        in   1 = store, 0 = load
//   req_size      in   0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned  in   zero-extend byte/half loads
//   req_addr      in   byte address [DATAMEM_BITS+1:0]
//   req_wdata     in   right-aligned store data
//   rsp_valid     out  one-cycle response pulse
//   rsp_rdata     out  extended load data (0 for stores and errors)
//   rsp_err       out  request rejected, no access made
//   dm_write      out  byte-lane write enables, bit k = byte offset k
//   data_addr     out  word address to data memory
//   data_in       out  write data, byte offset k on bits [31-8k:24-8k]
//   data_out      in   read data (1-cycle latency), offset k on [8k+7:8k]
// ============================================================================
module dm_lsu #(
    parameter int DATAMEM_BITS = 14
) (
    input  logic                    core_clk,
    input  logic                    nrst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATAMEM_BITS+1:0] req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic [3:0]              dm_write,
    output logic [DATAMEM_BITS-1:0] data_addr,
    output logic [31:0]             data_in,
    input  logic [31:0]             data_out
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ISSUE    = 3'd1;
    localparam logic [2:0] CAPTURE  = 3'd2;
    localparam logic [2:0] RESP     = 3'd5;
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
    localparam logic [2:0] ISSUE2   = 3'd3;
    localparam logic [2:0] CAPTURE2 = 3'd4;
    localparam logic [DATAMEM_BITS-1:0] c_WORD_ONE = {{(DATAMEM_BITS-1){1'b0}}, 1'b1};
`endif

    // The memory write port is big-endian by lane: offset 0 sits in the top
    // byte. Internally data is kept little-endian and swapped on the way out.
    function automatic logic [31:0] f_lane_swap(input logic [31:0] d);
        f_lane_swap = {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [2:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;

    logic [3:0]  w_smask;
    logic        w_illegal;
    logic [3:0]  w_mask_lo;
    logic [31:0] w_st_lo;
    logic [31:0] w_ld_raw;
    logic [31:0] w_ld_ext;

`ifdef DM_LSU_MISALIGNED_SPLIT_EN
    logic [6:0]  w_mask7;
    logic [63:0] w_st64;
    logic [63:0] w_ld64;
    logic        r_split;
    logic [2:0]  r_mask_hi;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_lo_word;
`else
    logic        w_misaligned;
`endif

    assign req_ready = (r_state == IDLE);

    // Lane mask of the access before it is shifted to its byte offset.
    always_comb begin
        case (req_size)
            2'd0:    w_smask = 4'b0001;
            2'd1:    w_smask = 4'b0011;
            default: w_smask = 4'b1111;
        endcase
    end

`ifdef DM_LSU_MISALIGNED_SPLIT_EN
    // Shift mask and data across a two-word window; bits above lane 3 belong
    // to the following word and are replayed by the second access.
    assign w_mask7   = {3'b000, w_smask} << req_addr[1:0];
    assign w_st64    = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    assign w_mask_lo = w_mask7[3:0];
    assign w_st_lo   = w_st64[31:0];
    assign w_illegal = (req_size == 2'd3);
    // In CAPTURE2 the first word was parked in r_lo_word; data_out holds the
    // second word, so the shifted window yields the crossing bytes in order.
    assign w_ld64    = (r_state == CAPTURE2) ? {data_out, r_lo_word} : {32'h0, data_out};
    assign w_ld_raw  = 32'(w_ld64 >> {r_off, 3'b000});
`else
    assign w_mask_lo    = w_smask << req_addr[1:0];
    assign w_st_lo      = req_wdata << {req_addr[1:0], 3'b000};
    assign w_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign w_illegal    = (req_size == 2'd3) || w_misaligned;
    assign w_ld_raw     = data_out >> {r_off, 3'b000};
`endif

    always_comb begin
        case (r_size)
            2'd0:    w_ld_ext = r_unsigned ? {24'h0, w_ld_raw[7:0]}
                                           : {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            2'd1:    w_ld_ext = r_unsigned ? {16'h0, w_ld_raw[15:0]}
                                           : {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            default: w_ld_ext = w_ld_raw;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off      <= 2'd0;
            dm_write   <= 4'b0000;
            data_addr  <= '0;
            data_in    <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
            r_split    <= 1'b0;
            r_mask_hi  <= 3'b000;
            r_wdata_hi <= 32'h0;
            r_lo_word  <= 32'h0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[1:0];
                        if (w_illegal) begin
                            // Rejected without touching the memory port.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            r_state   <= RESP;
                        end else begin
                            data_addr <= req_addr[DATAMEM_BITS+1:2];
                            dm_write  <= req_we ? w_mask_lo : 4'b0000;
                            data_in   <= f_lane_swap(w_st_lo);
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
                            r_split    <= |w_mask7[6:4];
                            r_mask_hi  <= w_mask7[6:4];
                            r_wdata_hi <= w_st64[63:32];
`endif
                            r_state   <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
                    if (r_we && r_split) begin
                        // Second half of a crossing store goes out next cycle.
                        data_addr <= data_addr + c_WORD_ONE;
                        dm_write  <= {1'b0, r_mask_hi};
                        data_in   <= f_lane_swap(r_wdata_hi);
                        r_state   <= ISSUE2;
                    end else
`endif
                    if (r_we) begin
                        dm_write  <= 4'b0000;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        r_state   <= RESP;
                    end else begin
                        dm_write  <= 4'b0000;
                        r_state   <= CAPTURE;
                    end
                end

                CAPTURE: begin
`ifdef DM_LSU_MISALIGNED_SPLIT_EN
                    if (r_split) begin
                        r_lo_word <= data_out;
                        data_addr <= data_addr + c_WORD_ONE;
                        r_state   <= ISSUE2;
                    end else
`endif
                    begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= w_ld_ext;
                        r_state   <= RESP;
                    end
                end

`ifdef DM_LSU_MISALIGNED_SPLIT_EN
                ISSUE2: begin
                    dm_write <= 4'b0000;
                    if (r_we) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        r_state   <= RESP;
                    end else begin
                        r_state   <= CAPTURE2;
                    end
                end

                CAPTURE2: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= w_ld_ext;
                    r_state   <= RESP;
                end
`endif

                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    r_state   <= IDLE;
                end

                default: begin
                    dm_write <= 4'b0000;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
